// File: rtl/hdmi_tx_pkg.sv
// Shared types and constants for the HDMI transmit formatter: timing-meter
// FSM states, the colour-bar table and the default underflow blanking colour.
package hdmi_tx_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } tm_state_e;

  localparam logic [23:0] BLANK_COLOR_DEFAULT = 24'h000000;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] COLOR_BARS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    return COLOR_BARS[idx];
  endfunction

endpackage

// File: rtl/video_timing_meter.sv
// Measures active width/height of the incoming video and locks onto a stable
// format; flags any line or frame that departs from the locked geometry.
module video_timing_meter
  import hdmi_tx_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de,
  input  logic             v_sync,
  output logic [CNT_W-1:0] pix_idx,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic             timing_err,
  output logic             vs_rise,
  output tm_state_e        state
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [7:0]       MATCH_TGT = 8'(LOCK_FRAMES - 1);

  tm_state_e        state_next;
  logic             de_q, vs_q;
  logic [CNT_W-1:0] pix_cnt, line_len, line_cnt, stored_w, stored_h;
  logic [7:0]       match_cnt, match_next;
  logic             store_en, clear_store, lock_en, err_now;
  logic             de_fall, de_rise;

  assign de_fall = de_q & ~de;
  assign de_rise = de & ~de_q;
  assign vs_rise = v_sync & ~vs_q;
  assign pix_idx = pix_cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_SEARCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    match_next  = match_cnt;
    store_en    = 1'b0;
    clear_store = 1'b0;
    lock_en     = 1'b0;
    err_now     = 1'b0;
    case (state)
      ST_SEARCH: begin
        // Stored geometry is cleared so the partial frame before this edge is never matched.
        if (vs_rise) begin
          state_next  = ST_MEASURE;
          match_next  = '0;
          clear_store = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (vs_rise) begin
          store_en = 1'b1;
          if (line_len == stored_w && line_cnt == stored_h &&
              line_len != '0 && line_cnt != '0) begin
            match_next = match_cnt + 8'd1;
            if (match_next == MATCH_TGT) begin
              state_next = ST_LOCKED;
              lock_en    = 1'b1;
            end
          end else begin
            match_next = '0;
          end
        end
      end
      ST_LOCKED: begin
        if ((de_fall && pix_cnt != h_active) || (vs_rise && line_cnt != v_active)) begin
          err_now    = 1'b1;
          state_next = ST_SEARCH;
        end
      end
      default: state_next = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      de_q       <= 1'b0;
      vs_q       <= 1'b0;
      pix_cnt    <= '0;
      line_len   <= '0;
      line_cnt   <= '0;
      stored_w   <= '0;
      stored_h   <= '0;
      match_cnt  <= '0;
      h_active   <= '0;
      v_active   <= '0;
      timing_err <= 1'b0;
    end else begin
      de_q       <= de;
      vs_q       <= v_sync;
      match_cnt  <= match_next;
      timing_err <= err_now;
      if (de) begin
        if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + CNT_W'(1);
      end else if (de_fall) begin
        line_len <= pix_cnt;
        pix_cnt  <= '0;
      end
      if (vs_rise)                            line_cnt <= '0;
      else if (de_rise && line_cnt != CNT_MAX) line_cnt <= line_cnt + CNT_W'(1);
      if (clear_store) begin
        stored_w <= '0;
        stored_h <= '0;
      end else if (store_en) begin
        stored_w <= line_len;
        stored_h <= line_cnt;
      end
      if (lock_en) begin
        h_active <= line_len;
        v_active <= line_cnt;
      end
    end
  end

endmodule

// File: rtl/hdmi_tx_formatter.sv
// Two-stage video pipeline from the clocked video output to the HDMI pins,
// with underflow blanking, sync polarity and timing lock reporting.
// Optional colour-bar generator enabled by defining HDMI_TX_FORMATTER_TPG_EN.
module hdmi_tx_formatter
  import hdmi_tx_pkg::*;
#(
  parameter int                DATA_W      = 24,
  parameter int                CNT_W       = 12,
  parameter logic [DATA_W-1:0] BLANK_COLOR = DATA_W'(BLANK_COLOR_DEFAULT),
  parameter int                LOCK_FRAMES = 2,
  parameter bit                HS_POL      = 1'b1,
  parameter bit                VS_POL      = 1'b1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_datavalid,
  input  logic              vid_h_sync,
  input  logic              vid_v_sync,
  input  logic              vid_underflow,
  input  logic              tpg_sel,
  output logic [DATA_W-1:0] hdmi_d,
  output logic              hdmi_de,
  output logic              hdmi_hs,
  output logic              hdmi_vs,
  output logic              locked,
  output logic [CNT_W-1:0]  h_active,
  output logic [CNT_W-1:0]  v_active,
  output logic [15:0]       underflow_cnt,
  output logic              timing_err
);

  localparam logic HS_IDLE = !HS_POL;
  localparam logic VS_IDLE = !VS_POL;

  tm_state_e         meter_state;
  logic [CNT_W-1:0]  pix_idx;
  logic              vs_rise;
  logic              blank_flag, blank_now;
  logic [DATA_W-1:0] pix_sel, d1;
  logic              de1, hs1, vs1;
  logic              unused_tpg;

  video_timing_meter #(
    .CNT_W       (CNT_W),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_meter (
    .clk        (clk_clk),
    .reset      (reset_reset),
    .de         (vid_datavalid),
    .v_sync     (vid_v_sync),
    .pix_idx    (pix_idx),
    .h_active   (h_active),
    .v_active   (v_active),
    .timing_err (timing_err),
    .vs_rise    (vs_rise),
    .state      (meter_state)
  );

  assign locked     = (meter_state == ST_LOCKED);
  assign unused_tpg = ^{tpg_sel, pix_idx};

  // The underflowing pixel itself is blanked; a v_sync rise ends blanking unless underflow repeats.
  assign blank_now = vid_underflow | (blank_flag & ~vs_rise);

`ifdef HDMI_TX_FORMATTER_TPG_EN
  always_comb begin
    pix_sel = blank_now ? BLANK_COLOR : vid_data;
    if (tpg_sel) pix_sel = DATA_W'(bar_color(pix_idx[9:7]));
  end
`else
  assign pix_sel = blank_now ? BLANK_COLOR : vid_data;
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      d1            <= '0;
      de1           <= 1'b0;
      hs1           <= 1'b0;
      vs1           <= 1'b0;
      blank_flag    <= 1'b0;
      underflow_cnt <= '0;
      hdmi_d        <= '0;
      hdmi_de       <= 1'b0;
      hdmi_hs       <= HS_IDLE;
      hdmi_vs       <= VS_IDLE;
    end else begin
      d1  <= pix_sel;
      de1 <= vid_datavalid;
      hs1 <= vid_h_sync;
      vs1 <= vid_v_sync;
      if (vid_underflow)  blank_flag <= 1'b1;
      else if (vs_rise)   blank_flag <= 1'b0;
      if (vid_underflow && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
      hdmi_d  <= de1 ? d1 : '0;
      hdmi_de <= de1;
      hdmi_hs <= hs1 ~^ HS_POL;
      hdmi_vs <= vs1 ~^ VS_POL;
    end
  end

endmodule

// File: tb/tb_hdmi_tx_formatter.sv
// Directed bench for hdmi_tx_formatter: 24x8 timing with 16x4 active video,
// pipeline scoreboard plus hand-computed lock, underflow and reset checks.
module tb_hdmi_tx_formatter;
  import hdmi_tx_pkg::*;

  localparam logic [23:0] BLANK     = 24'h123456;
  localparam logic [26:0] IDLE_WORD = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_reset, vid_datavalid, vid_h_sync, vid_v_sync, vid_underflow, tpg_sel;
  logic [23:0] vid_data;
  logic [23:0] hdmi_d, n_d;
  logic        hdmi_de, hdmi_hs, hdmi_vs, locked, timing_err;
  logic        n_de, n_hs, n_vs, n_locked, n_err;
  logic [11:0] h_active, v_active, n_h_active, n_v_active;
  logic [15:0] underflow_cnt, n_ucnt;

  hdmi_tx_formatter #(.DATA_W(24), .CNT_W(12), .BLANK_COLOR(BLANK), .LOCK_FRAMES(2),
                      .HS_POL(1'b1), .VS_POL(1'b1)) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .vid_data(vid_data),
    .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
    .vid_underflow(vid_underflow), .tpg_sel(tpg_sel), .hdmi_d(hdmi_d), .hdmi_de(hdmi_de),
    .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs), .locked(locked), .h_active(h_active),
    .v_active(v_active), .underflow_cnt(underflow_cnt), .timing_err(timing_err));

  hdmi_tx_formatter #(.DATA_W(24), .CNT_W(12), .BLANK_COLOR(BLANK), .LOCK_FRAMES(2),
                      .HS_POL(1'b0), .VS_POL(1'b0)) dut_n (
    .clk_clk(clk), .reset_reset(reset_reset), .vid_data(vid_data),
    .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
    .vid_underflow(vid_underflow), .tpg_sel(tpg_sel), .hdmi_d(n_d), .hdmi_de(n_de),
    .hdmi_hs(n_hs), .hdmi_vs(n_vs), .locked(n_locked), .h_active(n_h_active),
    .v_active(n_v_active), .underflow_cnt(n_ucnt), .timing_err(n_err));

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int frame_no = 0;
  logic [26:0] exp_q[$];
  logic [26:0] chk_exp_q[$];
  logic [26:0] chk_obs_q[$];
  logic m_bflag, m_vs_prev;
  int   m_pix;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef HDMI_TX_FORMATTER_TPG_EN
  function automatic logic [23:0] bar_ref(input int p);
    case ((p / 128) % 8)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction
`endif

  // Drives one pixel clock, queues the output expected two cycles later, records the observed output.
  task automatic drive_cycle(input logic [23:0] d, input logic de, input logic hs,
                             input logic vs, input logic uf);
    logic        vs_rise_m, blank;
    logic [23:0] ed;
    vid_data = d; vid_datavalid = de; vid_h_sync = hs; vid_v_sync = vs; vid_underflow = uf;
    vs_rise_m = vs & ~m_vs_prev;
    blank     = uf | (m_bflag & ~vs_rise_m);
    ed        = !de ? 24'h0 : (blank ? BLANK : d);
`ifdef HDMI_TX_FORMATTER_TPG_EN
    if (de && tpg_sel) ed = bar_ref(m_pix);
`endif
    exp_q.push_back({de, hs, vs, ed});
    m_bflag   = uf ? 1'b1 : (vs_rise_m ? 1'b0 : m_bflag);
    m_vs_prev = vs;
    m_pix     = de ? m_pix + 1 : 0;
    tick();
    chk_exp_q.push_back(exp_q.pop_front());
    chk_obs_q.push_back({hdmi_de, hdmi_hs, hdmi_vs, hdmi_d});
    if (timing_err) err_pulses++;
  endtask

  task automatic hold_reset(input int n);
    reset_reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic release_reset();
    reset_reset = 1'b0;
    exp_q.delete(); chk_exp_q.delete(); chk_obs_q.delete();
    exp_q.push_back(IDLE_WORD);
    m_bflag = 1'b0; m_vs_prev = 1'b0; m_pix = 0;
  endtask

  // 8 lines x 24 px: v_sync on line 0, active lines 3..6 with 16 px, h_sync px 18..20.
  task automatic send_frame(input int short_line, input int uf_line, input int uf_px);
    for (int ln = 0; ln < 8; ln++) begin
      for (int px = 0; px < 24; px++) begin
        drive_cycle({8'h80 + 8'(frame_no), 8'(ln), 8'(px)},
                    (ln >= 3 && ln <= 6) && (px < ((ln == short_line) ? 15 : 16)),
                    (px >= 18 && px <= 20), (ln == 0), (ln == uf_line && px == uf_px));
      end
    end
    frame_no++;
  endtask

  task automatic test_reset();
    vid_data = '0; vid_datavalid = 0; vid_h_sync = 0; vid_v_sync = 0;
    vid_underflow = 0; tpg_sel = 0;
    hold_reset(3);
    checks++;
    if ({hdmi_d, hdmi_de, hdmi_hs, hdmi_vs} !== 27'h0) begin
      errors++; $display("FAIL reset_video: got %h expected 0", {hdmi_d, hdmi_de, hdmi_hs, hdmi_vs});
    end
    checks++;
    if ({locked, h_active, v_active, underflow_cnt, timing_err} !== 41'h0) begin
      errors++; $display("FAIL reset_status: got %h expected 0",
                         {locked, h_active, v_active, underflow_cnt, timing_err});
    end
    checks++;
    if ({n_hs, n_vs} !== 2'b11) begin
      errors++; $display("FAIL reset_neg_sync_idle: got %b expected 11", {n_hs, n_vs});
    end
    checks++;
    if ({n_d, n_de, n_locked, n_h_active, n_v_active, n_ucnt, n_err} !== 66'h0) begin
      errors++; $display("FAIL reset_neg_rest: got %h expected 0",
                         {n_d, n_de, n_locked, n_h_active, n_v_active, n_ucnt, n_err});
    end
    checks++;
    if (dut.u_meter.state !== ST_SEARCH) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dut.u_meter.state, ST_SEARCH);
    end
    release_reset();
  endtask

  task automatic test_polarity();
    logic [9:0]  hsp, vsp;
    logic [26:0] e, o;
    hsp = 10'b1011001010;
    vsp = 10'b0110010011;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(24'h0, 1'b0, hsp[k], vsp[k], 1'b0);
      if (k >= 1) begin
        checks++;
        if ({n_hs, n_vs} !== {~hsp[k-1], ~vsp[k-1]}) begin
          errors++; $display("FAIL polarity_neg k=%0d: got %b expected %b", k, {n_hs, n_vs},
                             {~hsp[k-1], ~vsp[k-1]});
        end
      end
    end
    while (chk_obs_q.size() > 0) begin
      e = chk_exp_q.pop_front(); o = chk_obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL polarity_video: got %h expected %h", o, e); end
    end
    hold_reset(2);
    release_reset();
  endtask

  task automatic test_lock();
    logic [26:0] e, o;
    send_frame(-1, -1, 0);
    send_frame(-1, -1, 0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0", locked); end
    send_frame(-1, -1, 0);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got %b expected 1", locked); end
    checks++;
    if (h_active !== 12'd16 || v_active !== 12'd4) begin
      errors++; $display("FAIL lock_geometry: got %0d x %0d expected 16 x 4", h_active, v_active);
    end
    checks++;
    if (err_pulses !== 0) begin errors++; $display("FAIL lock_no_err: got %0d expected 0", err_pulses); end
    while (chk_obs_q.size() > 0) begin
      e = chk_exp_q.pop_front(); o = chk_obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL lock_video: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_underflow();
    logic [26:0] e, o;
    int nblank, fn;
    bit seen;
    nblank = 0;
    send_frame(-1, 4, 5);
    while (chk_obs_q.size() > 0) begin
      e = chk_exp_q.pop_front(); o = chk_obs_q.pop_front(); checks++;
      if (o[26] && o[23:0] == BLANK) nblank++;
      if (o !== e) begin errors++; $display("FAIL underflow_video: got %h expected %h", o, e); end
    end
    checks++;
    if (nblank !== 43) begin errors++; $display("FAIL underflow_blank_px: got %0d expected 43", nblank); end
    checks++;
    if (underflow_cnt !== 16'd1) begin
      errors++; $display("FAIL underflow_cnt: got %0d expected 1", underflow_cnt);
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL underflow_locked: got %b expected 1", locked); end
    fn = frame_no;
    seen = 0;
    send_frame(-1, -1, 0);
    while (chk_obs_q.size() > 0) begin
      e = chk_exp_q.pop_front(); o = chk_obs_q.pop_front(); checks++;
      if (o[26] && !seen) begin
        seen = 1; checks++;
        if (o[23:0] !== {8'h80 + 8'(fn), 8'd3, 8'd0}) begin
          errors++; $display("FAIL underflow_recover: got %h expected %h", o[23:0],
                             {8'h80 + 8'(fn), 8'd3, 8'd0});
        end
      end
      if (o !== e) begin errors++; $display("FAIL underflow_next_video: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_timing_err();
    logic [26:0] e, o;
    err_pulses = 0;
    send_frame(4, -1, 0);
    checks++;
    if (err_pulses !== 1) begin errors++; $display("FAIL terr_pulses: got %0d expected 1", err_pulses); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL terr_unlock: got %b expected 0", locked); end
    send_frame(-1, -1, 0);
    send_frame(-1, -1, 0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL terr_relock_early: got %b expected 0", locked); end
    send_frame(-1, -1, 0);
    checks++;
    if (locked !== 1'b1 || h_active !== 12'd16 || v_active !== 12'd4) begin
      errors++; $display("FAIL terr_relock: got %b %0d %0d expected 1 16 4", locked, h_active, v_active);
    end
    checks++;
    if (err_pulses !== 1) begin errors++; $display("FAIL terr_single: got %0d expected 1", err_pulses); end
    while (chk_obs_q.size() > 0) begin
      e = chk_exp_q.pop_front(); o = chk_obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL terr_video: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_mid_reset();
    logic [26:0] e, o;
    for (int i = 0; i < 5; i++) drive_cycle(24'hA00000 + 24'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    while (chk_obs_q.size() > 0) begin
      e = chk_exp_q.pop_front(); o = chk_obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL midrst_pre_video: got %h expected %h", o, e); end
    end
    vid_data = 24'hBEEF01;
    hold_reset(1);
    checks++;
    if ({hdmi_d, hdmi_de, hdmi_hs, hdmi_vs, locked, underflow_cnt, h_active} !== 56'h0) begin
      errors++; $display("FAIL midrst_outputs: got %h expected 0",
                         {hdmi_d, hdmi_de, hdmi_hs, hdmi_vs, locked, underflow_cnt, h_active});
    end
    hold_reset(2);
    checks++;
    if (dut.u_meter.state !== ST_SEARCH || {n_hs, n_vs} !== 2'b11) begin
      errors++; $display("FAIL midrst_state: got %0d %b expected %0d 11", dut.u_meter.state,
                         {n_hs, n_vs}, ST_SEARCH);
    end
    release_reset();
    drive_cycle(24'hC0FFEE, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hdmi_de !== 1'b0) begin errors++; $display("FAIL midrst_hold: got %b expected 0", hdmi_de); end
    drive_cycle(24'hC0FFEF, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({hdmi_de, hdmi_d} !== {1'b1, 24'hC0FFEE}) begin
      errors++; $display("FAIL midrst_resume: got %h expected 1c0ffee", {hdmi_de, hdmi_d});
    end
    for (int i = 0; i < 4; i++) drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (chk_obs_q.size() > 0) begin
      e = chk_exp_q.pop_front(); o = chk_obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL midrst_post_video: got %h expected %h", o, e); end
    end
  endtask

`ifdef HDMI_TX_FORMATTER_TPG_EN
  task automatic test_tpg();
    logic [26:0] e, o;
    logic [23:0] prev;
    int changes;
    bit first;
    changes = 0; first = 1; prev = '0;
    tpg_sel = 1'b1;
    for (int p = 0; p < 1024; p++) drive_cycle(24'($urandom), 1'b1, 1'b0, 1'b0, (p == 10));
    for (int i = 0; i < 4; i++) drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (chk_obs_q.size() > 0) begin
      e = chk_exp_q.pop_front(); o = chk_obs_q.pop_front(); checks++;
      if (o[26]) begin
        if (!first && o[23:0] != prev) changes++;
        first = 0; prev = o[23:0];
      end
      if (o !== e) begin errors++; $display("FAIL tpg_video: got %h expected %h", o, e); end
    end
    checks++;
    if (changes !== 7) begin errors++; $display("FAIL tpg_bar_edges: got %0d expected 7", changes); end
    tpg_sel = 1'b0;
  endtask
`else
  task automatic test_tpg_ignored();
    logic [26:0] e, o;
    tpg_sel = 1'b1;
    send_frame(-1, -1, 0);
    for (int i = 0; i < 2; i++) drive_cycle(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (chk_obs_q.size() > 0) begin
      e = chk_exp_q.pop_front(); o = chk_obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL tpg_ignored_video: got %h expected %h", o, e); end
    end
    tpg_sel = 1'b0;
  endtask
`endif

  initial begin
    reset_reset = 1'b1;
    test_reset();
    test_polarity();
    test_lock();
    test_underflow();
    test_timing_err();
    test_mid_reset();
`ifdef HDMI_TX_FORMATTER_TPG_EN
    test_tpg();
`else
    test_tpg_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
